exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception/interrupt arbiter sitting directly upstream of the CP0 register file.
- Collects exception flags and ERET from the memory stage, plus hardware interrupt lines.
- Prioritises them, then drives CP0 writes: epc_in, cause_in, write enables, input select and status push/pop.
- Issues pipeline flush and PC redirect (exception vector or EPC).

Parameters:
EXC_VECTOR, 32'h8000_0180, redirect target for all exceptions and interrupts
FLUSH_CYCLES, 2, cycles flush stays asserted after commit (legal range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pause  in  1  pipeline stall; CP0 ignores writes while high
ex_valid  in  1  valid instruction present in memory stage
ex_pc  in  32  PC of that instruction
ex_bd  in  1  instruction is in a branch delay slot
exc_adel_if, exc_ri, exc_ovf, exc_sys, exc_bp, exc_adel_mem, exc_ades  in  1 each  exception flags, qualified by ex_valid
ex_eret  in  1  ERET/RFE in memory stage
hw_int  in  6  external interrupt lines
status_i  in  32  CP0 status_out
epc_i  in  32  CP0 epc_out
cp0_wen  out  3  bit0 epc, bit1 cause, bit2 status
cp0_in_sel  out  1  1 = CP0 takes epc_in/cause_in/shift path
status_shift_sel  out  1  1 = pop (shift right 2), 0 = push (shift left 2)
cause_o  out  32  to CP0 cause_in
epc_o  out  32  to CP0 epc_in
flush  out  1  kill IF..MEM
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  32  new fetch address

Behaviour:
- Reset: state IDLE, counter 0, interrupt sync flops 0. All outputs 0.
- Interrupt request: int_req = status_i[0] & |(hw_int_s & status_i[15:10]), where hw_int_s is the sampled/synchronised hw_int.
- Priority, highest first: adel_if(4), ri(10), ovf(12), sys(8), bp(9), adel_mem(4), ades(5), interrupt(0), eret. Values in parentheses are ExcCode.
- An event exists only when ex_valid=1.
- Exception and eret on the same instruction: the exception wins.
- cause_o fields: [31]=ex_bd, [15:10]=hw_int_s, [6:2]=ExcCode, all other bits 0.
- epc_o: ex_pc when ex_bd=0, ex_pc-4 when ex_bd=1 (mod 2^32).
- States:
  - IDLE: outputs 0. On event, latch cause/epc/kind (exception or eret) and go to COMMIT. Events are latched even while pause=1.
  - COMMIT:
    - Exception: cp0_wen=3'b111, cp0_in_sel=1, status_shift_sel=0, redirect_pc=EXC_VECTOR.
    - Eret: cp0_wen=3'b100, cp0_in_sel=1, status_shift_sel=1, redirect_pc=epc_i.
    - flush=1.
    - pause=1: hold COMMIT with outputs stable; redirect_valid=0.
    - pause=0: redirect_valid=1 for exactly that cycle; load counter=FLUSH_CYCLES-1; go to FLUSH, or straight to IDLE if FLUSH_CYCLES=1.
  - FLUSH: flush=1, cp0_wen=0, all inputs ignored. Counter decrements; at 0 go to IDLE.
- Latched values are stable for the whole COMMIT/FLUSH episode; inputs changing meanwhile do not affect them.
- Reset in any state returns to IDLE the next edge; no partial CP0 write is issued.

Optional Feature:
- Macro EXC_IRQ_SYNC_EN.
- Defined: hw_int passes through a two-flop synchroniser, giving 2-cycle interrupt detection latency.
- Undefined: a single register stage, giving 1-cycle latency.

Decomposition:
- Shared package/header exc_defs: ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), cp0_wen bit indices, state encodings.
- One sub-module exc_prio_enc: combinational priority encoder, flags to {valid, ExcCode}.

Test Plan:
- ex_valid=1, exc_ovf=1, ex_pc=0x0040_0010, ex_bd=0, pause=0 → next cycle COMMIT:
  - cp0_wen=111, cause_o=0x0000_0030, epc_o=0x0040_0010.
  - redirect_valid=1 with redirect_pc=0x8000_0180.
  - flush high 2 cycles, then IDLE.
- exc_sys=1 with ex_bd=1, ex_pc=0x100 → epc_o=0xFC, cause_o=0x8000_0020.
- exc_ri=1 and exc_bp=1 together → ExcCode 10.
- ex_eret=1 with no flag, epc_i=0x1234 → cp0_wen=100, status_shift_sel=1, redirect_pc=0x1234.
- ex_eret=1 with exc_ades=1 → exception path taken, ExcCode 5.
- status_i=0x0000_0401, hw_int[0] rises, ex_valid=1:
  - Interrupt commit after sync latency (2 cycles with EXC_IRQ_SYNC_EN, 1 cycle without).
  - ExcCode 0, cause_o[10]=1.
  - Repeat with status_i[0]=0 → no event.
- Pause held 3 cycles in COMMIT: outputs stable and redirect_valid stays 0 until pause drops.
- Separately, reset asserted during FLUSH → IDLE with all outputs 0 next cycle.

Source files
------------

// File: rtl/exc_defs.sv
// Shared definitions for the exception controller: ExcCodes, CP0 write-enable bit positions, FSM states.
package exc_defs;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int WEN_EPC    = 0;
   localparam int WEN_CAUSE  = 1;
   localparam int WEN_STATUS = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   // Cause register image: BD in bit 31, pending lines in 15:10, ExcCode in 6:2.
   function automatic logic [31:0] mk_cause(input logic bd, input logic [5:0] ip,
                                            input logic [4:0] code);
      return {bd, 15'd0, ip, 3'd0, code, 2'd0};
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: memory-stage flags, interrupt and ERET to {valid, eret, ExcCode}.
module exc_prio_enc
   import exc_defs::*;
(
   input  logic       ex_valid,
   input  logic       exc_adel_if,
   input  logic       exc_ri,
   input  logic       exc_ovf,
   input  logic       exc_sys,
   input  logic       exc_bp,
   input  logic       exc_adel_mem,
   input  logic       exc_ades,
   input  logic       int_req,
   input  logic       ex_eret,
   output logic       evt_vld,
   output logic       evt_eret,
   output logic [4:0] exc_code
);

   always_comb begin
      evt_vld  = 1'b0;
      evt_eret = 1'b0;
      exc_code = EXC_INT;
      if (ex_valid) begin
         evt_vld = 1'b1;
         if      (exc_adel_if)  exc_code = EXC_ADEL;
         else if (exc_ri)       exc_code = EXC_RI;
         else if (exc_ovf)      exc_code = EXC_OV;
         else if (exc_sys)      exc_code = EXC_SYS;
         else if (exc_bp)       exc_code = EXC_BP;
         else if (exc_adel_mem) exc_code = EXC_ADEL;
         else if (exc_ades)     exc_code = EXC_ADES;
         else if (int_req)      exc_code = EXC_INT;
         else if (ex_eret)      evt_eret = 1'b1;
         else                   evt_vld  = 1'b0;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter driving CP0 writes, flush and PC redirect; commit one cycle after the event, held while pause=1.
// EXC_IRQ_SYNC_EN selects a two-flop hw_int synchroniser (2-cycle detect) instead of a single register stage.
module exc_ctrl
   import exc_defs::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pause,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_bd,
   input  logic        exc_adel_if,
   input  logic        exc_ri,
   input  logic        exc_ovf,
   input  logic        exc_sys,
   input  logic        exc_bp,
   input  logic        exc_adel_mem,
   input  logic        exc_ades,
   input  logic        ex_eret,
   input  logic [5:0]  hw_int,
   input  logic [31:0] status_i,
   input  logic [31:0] epc_i,
   output logic [2:0]  cp0_wen,
   output logic        cp0_in_sel,
   output logic        status_shift_sel,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        eret_q, eret_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [5:0]  hw_int_s_q, hw_int_s_d;

   logic        int_req;
   logic        evt_vld;
   logic        evt_eret;
   logic [4:0]  exc_code;
   logic        unused_status;

   assign unused_status = ^{status_i[31:16], status_i[9:1]};

`ifdef EXC_IRQ_SYNC_EN
   logic [5:0] hw_int_meta_q, hw_int_meta_d;

   assign hw_int_meta_d = hw_int;
   assign hw_int_s_d    = hw_int_meta_q;

   always_ff @(posedge clk) begin
      if (reset) hw_int_meta_q <= '0;
      else       hw_int_meta_q <= hw_int_meta_d;
   end
`else
   assign hw_int_s_d = hw_int;
`endif

   assign int_req = status_i[0] & (|(hw_int_s_q & status_i[15:10]));

   exc_prio_enc u_prio (
      .ex_valid     (ex_valid),
      .exc_adel_if  (exc_adel_if),
      .exc_ri       (exc_ri),
      .exc_ovf      (exc_ovf),
      .exc_sys      (exc_sys),
      .exc_bp       (exc_bp),
      .exc_adel_mem (exc_adel_mem),
      .exc_ades     (exc_ades),
      .int_req      (int_req),
      .ex_eret      (ex_eret),
      .evt_vld      (evt_vld),
      .evt_eret     (evt_eret),
      .exc_code     (exc_code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         eret_q     <= 1'b0;
         cause_q    <= '0;
         epc_q      <= '0;
         hw_int_s_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         eret_q     <= eret_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         hw_int_s_q <= hw_int_s_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      eret_d           = eret_q;
      cause_d          = cause_q;
      epc_d            = epc_q;
      cp0_wen          = 3'b000;
      cp0_in_sel       = 1'b0;
      status_shift_sel = 1'b0;
      cause_o          = '0;
      epc_o            = '0;
      flush            = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;

      case (state_q)
         ST_IDLE: begin
            // Latch regardless of pause; only the commit waits for the pipeline.
            if (evt_vld) begin
               eret_d  = evt_eret;
               cause_d = evt_eret ? 32'd0 : mk_cause(ex_bd, hw_int_s_q, exc_code);
               epc_d   = evt_eret ? 32'd0 : (ex_bd ? ex_pc - 32'd4 : ex_pc);
               state_d = ST_COMMIT;
            end
         end

         ST_COMMIT: begin
            flush      = 1'b1;
            cp0_in_sel = 1'b1;
            if (eret_q) begin
               cp0_wen[WEN_STATUS] = 1'b1;
               status_shift_sel    = 1'b1;
               redirect_pc         = epc_i;
            end else begin
               cp0_wen[WEN_EPC]    = 1'b1;
               cp0_wen[WEN_CAUSE]  = 1'b1;
               cp0_wen[WEN_STATUS] = 1'b1;
               cause_o             = cause_q;
               epc_o               = epc_q;
               redirect_pc         = EXC_VECTOR;
            end
            if (!pause) begin
               redirect_valid = 1'b1;
               cnt_d          = 4'(FLUSH_CYCLES - 1);
               state_d        = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            // Commit cycle counts toward FLUSH_CYCLES, so the counter is loaded with one less.
            flush = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
